// File: rtl/cpu_bram_rmw.sv
// Byte-write front end for the CPU block RAM: turns masked word writes into read-modify-write.
// Optional macro CPU_BRAM_RMW_ERROR_EN reports out-of-range RAM accesses on o_error.
module cpu_bram_rmw #(
    parameter int WIDTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_request,
    input  logic               i_rw,
    input  logic [31:0]        i_address,
    input  logic [WIDTH/8-1:0] i_wmask,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_rdata,
    output logic               o_ready,
    output logic               o_error,
    output logic               o_bram_request,
    output logic               o_bram_rw,
    output logic [31:0]        o_bram_address,
    output logic [WIDTH-1:0]   o_bram_wdata,
    input  logic [WIDTH-1:0]   i_bram_rdata,
    input  logic               i_bram_ready,
    input  logic               i_bram_valid
);
    localparam int BYTES = WIDTH / 8;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_ISSUE = 3'd3;
    localparam logic [2:0] WR_WAIT  = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] RELEASE  = 3'd6;

    logic [2:0]       state;
    logic             rw_q;
    logic [BYTES-1:0] mask_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] merged;
    logic             bram_bad;
    logic [1:0]       unused_addr_bits;

    assign unused_addr_bits = i_address[1:0];

`ifdef CPU_BRAM_RMW_ERROR_EN
    assign bram_bad = ~i_bram_valid;
`else
    logic unused_valid;
    assign unused_valid = i_bram_valid;
    assign bram_bad     = 1'b0;
`endif

    // Bytes with a set mask bit come from the CPU, the rest keep the RAM contents.
    always_comb begin
        merged = i_bram_rdata;
        for (int b = 0; b < BYTES; b++) begin
            if (mask_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            rw_q           <= 1'b0;
            mask_q         <= '0;
            wdata_q        <= '0;
            o_rdata        <= '0;
            o_ready        <= 1'b0;
            o_error        <= 1'b0;
            o_bram_request <= 1'b0;
            o_bram_rw      <= 1'b0;
            o_bram_address <= '0;
            o_bram_wdata   <= '0;
        end else begin
            o_bram_request <= 1'b0;
            o_ready        <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_request) begin
                        rw_q           <= i_rw;
                        mask_q         <= i_wmask;
                        wdata_q        <= i_wdata;
                        o_bram_address <= {i_address[31:2], 2'b00};
                        o_error        <= 1'b0;
                        // RAM pulses are launched on the accepting edge so they appear in the ISSUE states.
                        if (i_rw && i_wmask == '1) begin
                            o_bram_request <= 1'b1;
                            o_bram_rw      <= 1'b1;
                            o_bram_wdata   <= i_wdata;
                            state          <= WR_ISSUE;
                        end else if (i_rw && i_wmask == '0) begin
                            state <= DONE;
                        end else begin
                            o_bram_request <= 1'b1;
                            o_bram_rw      <= 1'b0;
                            state          <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (i_bram_ready) begin
                        o_error <= bram_bad;
                        if (!rw_q) begin
                            o_rdata <= i_bram_rdata;
                            state   <= DONE;
                        end else if (bram_bad) begin
                            state <= DONE;
                        end else begin
                            o_bram_wdata   <= merged;
                            o_bram_request <= 1'b1;
                            o_bram_rw      <= 1'b1;
                            state          <= WR_ISSUE;
                        end
                    end
                end
                WR_ISSUE: state <= WR_WAIT;
                WR_WAIT: begin
                    if (i_bram_ready) begin
                        o_error <= bram_bad;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    o_ready <= 1'b1;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    if (!i_request) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bram_rmw.sv
// Self-checking bench for cpu_bram_rmw: directed plan steps plus random accesses against a word-level memory model.
module tb_cpu_bram_rmw;
    localparam int WIDTH = 32;
`ifdef CPU_BRAM_RMW_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_request = 1'b0;
    logic        i_rw = 1'b0;
    logic [31:0] i_address = '0;
    logic [3:0]  i_wmask = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_error;
    logic        o_bram_request;
    logic        o_bram_rw;
    logic [31:0] o_bram_address;
    logic [31:0] o_bram_wdata;
    logic [31:0] i_bram_rdata = '0;
    logic        i_bram_ready = 1'b0;
    logic        i_bram_valid = 1'b0;

    int n_compared = 0;
    int n_failed   = 0;
    int rd_pulses  = 0;
    int wr_pulses  = 0;
    int rdy_pulses = 0;
    logic [31:0] last_wdata = '0;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 i_clock = ~i_clock;

    cpu_bram_rmw #(.WIDTH(WIDTH)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
        .i_address(i_address), .i_wmask(i_wmask), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_ready(o_ready), .o_error(o_error),
        .o_bram_request(o_bram_request), .o_bram_rw(o_bram_rw),
        .o_bram_address(o_bram_address), .o_bram_wdata(o_bram_wdata),
        .i_bram_rdata(i_bram_rdata), .i_bram_ready(i_bram_ready), .i_bram_valid(i_bram_valid)
    );

    // Block RAM: 256 words below 0x400, answers one cycle after each request.
    always @(posedge i_clock) begin
        i_bram_ready <= o_bram_request;
        if (o_bram_request) begin
            i_bram_valid <= (o_bram_address < 32'h400);
            if (o_bram_address < 32'h400) begin
                if (o_bram_rw) ram[o_bram_address[9:2]] <= o_bram_wdata;
                else           i_bram_rdata <= ram[o_bram_address[9:2]];
            end else if (!o_bram_rw) begin
                i_bram_rdata <= 32'h0;
            end
        end
    end

    always @(posedge i_clock) begin
        if (o_bram_request && o_bram_rw) begin
            wr_pulses++;
            last_wdata = o_bram_wdata;
        end
        if (o_bram_request && !o_bram_rw) rd_pulses++;
        if (o_ready) rdy_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] mask);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_word[8*b +: 8];
        return r;
    endfunction

    task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] wd, input int hold,
                                 output int lat, output logic [31:0] rdata, output logic err,
                                 output logic got);
        int edges;
        edges = 0; got = 1'b0; rdata = '0; err = 1'b0; lat = -1;
        @(negedge i_clock);
        i_request = 1'b1; i_rw = rw; i_address = addr; i_wmask = mask; i_wdata = wd;
        for (int c = 0; c < 20; c++) begin
            @(posedge i_clock); #1;
            edges++;
            if (o_ready) begin
                got = 1'b1; rdata = o_rdata; err = o_error; lat = edges - 1;
                break;
            end
        end
        repeat (hold) @(posedge i_clock);
        @(negedge i_clock);
        i_request = 1'b0;
        i_wdata = $urandom;
        repeat (2) @(negedge i_clock);
    endtask

    // Runs one access and checks it against the word-level expectations.
    task automatic runAccess(input string tag, input logic rw, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wd, input int hold);
        int lat, rd0, wr0, rdy0, exp_lat, exp_rd, exp_wr;
        logic [31:0] rdata, exp_data, old_word;
        logic err, got, in_range, exp_err;
        in_range = (addr < 32'h400);
        old_word = in_range ? ref_mem[addr[9:2]] : 32'h0;
        exp_err  = 1'b0; exp_data = '0;
        if (!rw) begin
            exp_rd = 1; exp_wr = 0; exp_lat = 3; exp_data = old_word;
            exp_err = ERR_EN && !in_range;
        end else if (mask == 4'hF) begin
            exp_rd = 0; exp_wr = 1; exp_lat = 3; exp_data = wd;
            exp_err = ERR_EN && !in_range;
        end else if (mask == 4'h0) begin
            exp_rd = 0; exp_wr = 0; exp_lat = 1;
        end else if (ERR_EN && !in_range) begin
            exp_rd = 1; exp_wr = 0; exp_lat = 3; exp_err = 1'b1;
        end else begin
            exp_rd = 1; exp_wr = 1; exp_lat = 5; exp_data = merge_ref(old_word, wd, mask);
        end
        rd0 = rd_pulses; wr0 = wr_pulses; rdy0 = rdy_pulses;
        applyStimulus(rw, addr, mask, wd, hold, lat, rdata, err, got);
        checkOutput({tag, ".done"}, 32'(got), 32'd1);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, ".error"}, 32'(err), 32'(exp_err));
        checkOutput({tag, ".rd_pulses"}, 32'(rd_pulses - rd0), 32'(exp_rd));
        checkOutput({tag, ".wr_pulses"}, 32'(wr_pulses - wr0), 32'(exp_wr));
        checkOutput({tag, ".ready_pulses"}, 32'(rdy_pulses - rdy0), 32'd1);
        if (!rw) checkOutput({tag, ".rdata"}, rdata, exp_data);
        if (exp_wr == 1) begin
            checkOutput({tag, ".wdata"}, last_wdata, exp_data);
            if (in_range) ref_mem[addr[9:2]] = exp_data;
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0] m;
        int r0, w0;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ram[i] <= d;
            ref_mem[i] = d;
        end
        ram[8'h04] <= 32'hDEADBEEF; ref_mem[8'h04] = 32'hDEADBEEF;
        ram[8'h08] <= 32'h11223344; ref_mem[8'h08] = 32'h11223344;

        #12;
        checkOutput("reset.ready", 32'(o_ready), 32'd0);
        checkOutput("reset.bram_request", 32'(o_bram_request), 32'd0);
        checkOutput("reset.bram_address", o_bram_address, 32'd0);
        checkOutput("reset.rdata", o_rdata, 32'd0);
        @(negedge i_clock); i_reset = 1'b1;
        repeat (2) @(negedge i_clock);

        runAccess("read_deadbeef", 1'b0, 32'h10, 4'h0, 32'h0, 0);
        checkOutput("read_deadbeef.value", ref_mem[8'h04], 32'hDEADBEEF);
        runAccess("partial_0101", 1'b1, 32'h22, 4'b0101, 32'hAABBCCDD, 0);
        checkOutput("partial_0101.merged", last_wdata, 32'h11BB33DD);
        runAccess("partial_readback", 1'b0, 32'h20, 4'h0, 32'h0, 0);
        runAccess("full_mask", 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 0);
        runAccess("full_readback", 1'b0, 32'h30, 4'h0, 32'h0, 0);
        runAccess("empty_mask", 1'b1, 32'h34, 4'h0, 32'h12345678, 0);
        runAccess("empty_readback", 1'b0, 32'h34, 4'h0, 32'h0, 0);
        runAccess("held_request", 1'b0, 32'h40, 4'h0, 32'h0, 10);
        runAccess("out_of_range", 1'b1, 32'h800, 4'b0011, 32'h55667788, 0);

        // Reset while the read phase of a partial write is outstanding.
        w0 = wr_pulses;
        @(negedge i_clock);
        i_request = 1'b1; i_rw = 1'b1; i_address = 32'h50; i_wmask = 4'b0010; i_wdata = 32'hFFFFFFFF;
        @(posedge i_clock); @(posedge i_clock);
        @(negedge i_clock); #1;
        i_reset = 1'b0; i_request = 1'b0;
        #1;
        checkOutput("midreset.outputs",
                    32'({o_ready, o_error, o_bram_request, o_bram_rw}), 32'd0);
        checkOutput("midreset.bram_address", o_bram_address, 32'd0);
        checkOutput("midreset.bram_wdata", o_bram_wdata, 32'd0);
        checkOutput("midreset.rdata", o_rdata, 32'd0);
        #1; i_reset = 1'b1;
        repeat (4) @(negedge i_clock);
        checkOutput("midreset.no_write", 32'(wr_pulses - w0), 32'd0);
        r0 = rdy_pulses;
        checkOutput("midreset.no_ready", 32'(rdy_pulses - r0), 32'd0);
        runAccess("after_reset_read", 1'b0, 32'h50, 4'h0, 32'h0, 0);

        for (int k = 0; k < 24; k++) begin
            a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
            m = 4'($urandom);
            if (k % 6 == 0) m = 4'hF;
            if (k % 6 == 3) m = 4'h0;
            runAccess($sformatf("rand%0d", k), 1'($urandom), a, m, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule

// File: doc/cpu_bram_rmw.md
# cpu_bram_rmw

Byte-write front end for the CPU block RAM. Sits directly upstream of the block RAM and accepts CPU word accesses with a per-byte write mask. It turns each partial-word write into a read-modify-write on the RAM's word-only port. Full-word writes and reads pass through as single RAM accesses.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8; mask width is WIDTH/8.

Ports:
- i_clock  in  1  the single clock for the block.
- i_reset  in  1  asynchronous, active-low reset.
- i_request  in  1  CPU access request; held high until o_ready.
- i_rw  in  1  0 = read, 1 = write.
- i_address  in  32  byte address; bits [1:0] ignored.
- i_wmask  in  WIDTH/8  byte-enable; bit n covers i_wdata[8n+7:8n].
- i_wdata  in  WIDTH  write data.
- o_rdata  out  WIDTH  read data; valid while o_ready.
- o_ready  out  1  one-cycle completion pulse.
- o_error  out  1  address-range error; valid while o_ready.
- o_bram_request  out  1  RAM request; always a single-cycle pulse.
- o_bram_rw  out  1  RAM read/write select.
- o_bram_address  out  32  RAM byte address; latched i_address with [1:0] = 0.
- o_bram_wdata  out  WIDTH  RAM write data.
- i_bram_rdata  in  WIDTH  RAM read data.
- i_bram_ready  in  1  RAM completion; arrives one cycle after o_bram_request.
- i_bram_valid  in  1  RAM address-in-range flag.

## Operation
- All outputs are registered.
- Reset values: o_rdata=0, o_ready=0, o_error=0, o_bram_request=0, o_bram_rw=0, o_bram_address=0, o_bram_wdata=0. State resets to IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE, RELEASE.
- IDLE, on i_request=1:
  - Latch address, rw, mask and wdata.
  - Read, or write with mask != 0: go to RD_ISSUE.
  - Write with mask == all ones: go to WR_ISSUE. No read is performed.
  - Write with mask == 0: go to DONE. No RAM access.
- RD_ISSUE: o_bram_request=1, o_bram_rw=0 for exactly one cycle, then RD_WAIT.
- RD_WAIT, on i_bram_ready:
  - Read: capture i_bram_rdata into o_rdata, then go to DONE.
  - Partial write: merge into o_bram_wdata. Each byte comes from i_wdata where the mask bit is 1, otherwise from i_bram_rdata. Then go to WR_ISSUE.
- WR_ISSUE: o_bram_request=1, o_bram_rw=1 with the merged or full data for one cycle, then WR_WAIT.
- WR_WAIT: on i_bram_ready, go to DONE.
- DONE: o_ready=1 for exactly one cycle, then RELEASE.
- RELEASE: wait for i_request=0, then IDLE.
  - A request held high continuously is never re-accepted.
  - A new access requires at least one low cycle of i_request.
- i_bram_ready is ignored in every state except RD_WAIT and WR_WAIT, so stale pulses are discarded.
- Request fields are sampled only in IDLE. Changes while busy are ignored.

## Timing
- Edge E0 samples i_request in IDLE.
- Read: o_bram_request high after E0; ready sampled at E2; o_ready high after E3.
- Full write: same cycle count as a read.
- Partial write: read pulse after E0, write pulse after E2, o_ready high after E5.
- Zero-mask write: o_ready high after E1.
- Throughput: at most one access per 5 cycles for reads and full writes, 7 for partial writes. The count includes the RELEASE low cycle.
- Asynchronous reset mid-operation:
  - All outputs clear immediately and the state returns to IDLE.
  - A RAM write already pulsed may have landed; a pending partial write is dropped.
  - The RAM ready pulse that follows is ignored.

## Configuration
- Macro: CPU_BRAM_RMW_ERROR_EN.
- Defined:
  - o_error = !i_bram_valid, latched at the last RAM completion of the access.
  - If the read phase of a partial write returns i_bram_valid=0, the write phase is skipped: RD_WAIT goes to DONE with o_error=1 and the RAM is not written.
- Undefined:
  - o_error is tied to 0 and i_bram_valid is unused.
  - Partial writes always perform the write phase.

## Test plan
- Read: RAM word 0x10 = 0xDEADBEEF; read address 0x10 -> one read pulse, o_rdata=0xDEADBEEF, o_ready 3 edges after request, o_error=0.
- Partial write: word 0x20 = 0x11223344; write 0xAABBCCDD with mask 4'b0101 -> read pulse, then write pulse with wdata 0x11BB33DD; readback returns 0x11BB33DD.
- Full and empty masks: mask 4'b1111 -> single write pulse, no read. Mask 4'b0000 -> no RAM pulse, o_ready after E1.
- Held request: i_request held high for 10 cycles -> exactly one access and one o_ready pulse.
- Out of range, with CPU_BRAM_RMW_ERROR_EN: partial write with i_bram_valid=0 -> o_error=1, no write pulse. Without the macro -> o_error=0 and a write pulse occurs.
- Reset mid-operation: assert i_reset low in RD_WAIT of a partial write -> all outputs 0 at once, no write pulse. After release, the stale i_bram_ready is ignored and the next read completes normally.
